// File: rtl/rand_mstream_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : rand_mstream_gen_if
// Purpose  : 32-bit register-slave bus between the address decoder/master
//            and the multi-stream random number generator.
// Revision : 1.0 - initial release
// ============================================================================
interface rand_mstream_gen_if;
  logic        cs_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        busy_o;

  modport slave (
    input  cs_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, busy_o
  );

  modport master (
    output cs_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/rand_mstream_gen.sv
`default_nettype none
// ============================================================================
// Module   : rand_mstream_gen
// Purpose  : Multi-stream Marsaglia multiply-with-carry generator behind a
//            32-bit register slave. Per-stream z/w state lives in two RAMs,
//            seeded by a hardware init-all sequencer after reset/on command.
// Revision : 1.0 - initial release
// ============================================================================
module rand_mstream_gen #(
  parameter int unsigned STREAMS = 1024,
  parameter logic [31:0] INIT_Z  = 32'd17,
  parameter logic [31:0] INIT_W  = 32'd3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  rand_mstream_gen_if.slave bus
);

  localparam int unsigned SW = $clog2(STREAMS);

  localparam logic [2:0] c_REG_RAND   = 3'd0;
  localparam logic [2:0] c_REG_STREAM = 3'd1;
  localparam logic [2:0] c_REG_ZSEED  = 3'd2;
  localparam logic [2:0] c_REG_WSEED  = 3'd3;
  localparam logic [2:0] c_REG_CTRL   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_ACK  = 2'd2,
    S_INIT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Per-stream state and its registered read ports
  logic [31:0] r_zram [STREAMS];
  logic [31:0] r_wram [STREAMS];
  logic [31:0] r_zq;
  logic [31:0] r_wq;

  // Control/status and latched request
  logic [SW-1:0] r_stream;
  logic          r_auto;
  logic [SW-1:0] r_idx;
  logic [2:0]    r_reg;
  logic          r_we;
  logic [31:0]   r_dat;
  logic          r_ack;
  logic [31:0]   r_dato;

  logic          w_accept;
  logic          w_last;
  logic          w_init_cmd;
  logic [31:0]   w_z_adv;
  logic [31:0]   w_w_adv;
  logic [31:0]   w_init_z;
  logic [31:0]   w_init_w;
  logic [31:0]   w_rdata;
  logic          w_z_we;
  logic          w_w_we;
  logic [SW-1:0] w_waddr;
  logic [31:0]   w_zwd;
  logic [31:0]   w_wwd;
  logic          w_unused_adr;

  // Only adr[4:2] are decoded; fold the rest so they are visibly consumed
  assign w_unused_adr = ^{bus.adr_i[31:5], bus.adr_i[1:0]};

  assign w_accept   = (r_state == S_IDLE) && bus.cs_i && bus.stb_i && !r_ack;
  assign w_last     = (r_idx == SW'(STREAMS - 1));
  assign w_init_cmd = r_we && (r_reg == c_REG_CTRL) && r_dat[1];

  // Advance rule; operands are 16 bits so the 32-bit sums never overflow
  assign w_z_adv = 32'd36969 * {16'd0, r_zq[15:0]} + {16'd0, r_zq[31:16]};
  assign w_w_adv = 32'd18000 * {16'd0, r_wq[15:0]} + {16'd0, r_wq[31:16]};

  // Init-all seeds: z = INIT_Z + i, w = INIT_W + 2*i (mod 2^32)
  assign w_init_z = INIT_Z + {{(32-SW){1'b0}}, r_idx};
  assign w_init_w = INIT_W + {{(31-SW){1'b0}}, r_idx, 1'b0};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_RD;
      S_RD:   w_next = S_ACK;
      S_ACK:  w_next = w_init_cmd ? S_INIT : S_IDLE;
      S_INIT: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // RAM write-back selection: init-all sweep or ACK-cycle update
  always_comb begin
    w_z_we  = 1'b0;
    w_w_we  = 1'b0;
    w_waddr = r_stream;
    w_zwd   = w_z_adv;
    w_wwd   = w_w_adv;
    if (r_state == S_INIT) begin
      w_z_we  = 1'b1;
      w_w_we  = 1'b1;
      w_waddr = r_idx;
      w_zwd   = (w_init_z == 32'd0) ? INIT_Z : w_init_z;
      w_wwd   = (w_init_w == 32'd0) ? INIT_W : w_init_w;
    end else if (r_state == S_ACK) begin
      if (r_reg == c_REG_RAND && (r_we || r_auto)) begin
        w_z_we = 1'b1;
        w_w_we = 1'b1;
      end else if (r_we && r_reg == c_REG_ZSEED) begin
        w_z_we = 1'b1;
        w_zwd  = (r_dat == 32'd0) ? INIT_Z : r_dat;
      end else if (r_we && r_reg == c_REG_WSEED) begin
        w_w_we = 1'b1;
        w_wwd  = (r_dat == 32'd0) ? INIT_W : r_dat;
      end
    end
  end

  // Register read mux, evaluated in RD from the pre-advance RAM data
  always_comb begin
    w_rdata = 32'd0;
    case (r_reg)
      c_REG_RAND:   w_rdata = {r_zq[15:0], 16'h0000} + r_wq;
      c_REG_STREAM: w_rdata = {{(32-SW){1'b0}}, r_stream};
      c_REG_ZSEED:  w_rdata = r_zq;
      c_REG_WSEED:  w_rdata = r_wq;
      c_REG_CTRL:   w_rdata = {30'd0, (r_state == S_INIT), r_auto};
      default:      w_rdata = 32'd0;
    endcase
  end

  // Stream state RAMs: one write port, read port addressed by STREAM
  always_ff @(posedge clk_i) begin
    if (w_z_we) r_zram[w_waddr] <= w_zwd;
    if (w_w_we) r_wram[w_waddr] <= w_wwd;
    r_zq <= r_zram[r_stream];
    r_wq <= r_wram[r_stream];
  end

  // Request latch, control registers, init index and bus response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stream <= '0;
      r_auto   <= 1'b0;
      r_idx    <= '0;
      r_reg    <= 3'd0;
      r_we     <= 1'b0;
      r_dat    <= 32'd0;
      r_ack    <= 1'b0;
      r_dato   <= 32'd0;
    end else begin
      r_ack  <= (r_state == S_RD);
      r_dato <= (r_state == S_RD) ? w_rdata : 32'd0;
      if (w_accept) begin
        r_reg <= bus.adr_i[4:2];
        r_we  <= bus.we_i;
        r_dat <= bus.dat_i;
      end
      if (r_state == S_ACK && r_we) begin
        if (r_reg == c_REG_STREAM) r_stream <= r_dat[SW-1:0];
        if (r_reg == c_REG_CTRL)   r_auto   <= r_dat[0];
      end
      if (r_state == S_INIT)
        r_idx <= w_last ? '0 : r_idx + SW'(1);
      else if (r_state == S_ACK && w_init_cmd)
        r_idx <= '0;
    end
  end

  assign bus.dat_o  = r_dato;
  assign bus.ack_o  = r_ack;
  assign bus.busy_o = (r_state == S_INIT);

endmodule
`default_nettype wire
